alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// Single-issue SPARC v8 integer sequencer: latches one format-3/SETHI instruction,
// reads operands, drives an external registered ALU and retires to the register file.
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [31:0] inst,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [31:0] alu_r1,
  output logic [31:0] alu_r2,
  output logic [6:0]  alu_instruction,
  output logic        alu_operate,
  input  logic [31:0] alu_rd,
  input  logic [3:0]  alu_icc,
  input  logic [31:0] alu_y,
  input  logic        alu_dbz,
  input  logic        alu_tof,
  output logic [3:0]  icc,
  output logic [31:0] y,
  output logic        done,
  output logic        trap_valid,
  output logic [1:0]  trap_type
);

  localparam int unsigned CODE_W = 7;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_RESULT = 2'd2;
  localparam logic [1:0] S_CLEAR  = 2'd3;

  localparam logic [CODE_W-1:0] CODE_CLEAR = CODE_W'(36);

  logic [1:0]        state_q, state_d;
  logic [31:0]       inst_q;
  logic [CODE_W-1:0] code;
  logic              legal, is_sethi, is_shift, is_div, is_tv, cc_op, y_op;
  logic [5:0]        op3;
  logic [31:0]       op2_sel;
  logic              icc_ld, y_ld;

  // ALU dbz flag is redundant: divisor is checked before issue
  logic unused_ok;
  assign unused_ok = alu_dbz;

  assign op3      = inst_q[24:19];
  assign is_sethi = (inst_q[31:30] == 2'b00) && (inst_q[24:22] == 3'b100);
  assign rs1_addr = inst_q[18:14];
  assign rs2_addr = inst_q[4:0];
  assign wb_addr  = inst_q[29:25];

  // op3 -> ALU operation code
  always_comb begin
    code  = '0;
    legal = 1'b0;
    if (inst_q[31:30] == 2'b10) begin
      legal = 1'b1;
      case (op3)
        6'h00: code = CODE_W'(14);
        6'h01: code = CODE_W'(1);
        6'h02: code = CODE_W'(3);
        6'h03: code = CODE_W'(7);
        6'h04: code = CODE_W'(20);
        6'h06: code = CODE_W'(5);
        6'h07: code = CODE_W'(9);
        6'h08: code = CODE_W'(16);
        6'h0A: code = CODE_W'(27);
        6'h0B: code = CODE_W'(31);
        6'h0C: code = CODE_W'(22);
        6'h0E: code = CODE_W'(29);
        6'h0F: code = CODE_W'(33);
        6'h10: code = CODE_W'(15);
        6'h11: code = CODE_W'(2);
        6'h12: code = CODE_W'(4);
        6'h13: code = CODE_W'(8);
        6'h14: code = CODE_W'(21);
        6'h16: code = CODE_W'(6);
        6'h17: code = CODE_W'(10);
        6'h18: code = CODE_W'(17);
        6'h1A: code = CODE_W'(28);
        6'h1B: code = CODE_W'(32);
        6'h1C: code = CODE_W'(23);
        6'h1E: code = CODE_W'(30);
        6'h1F: code = CODE_W'(34);
        6'h20: code = CODE_W'(18);
        6'h21: code = CODE_W'(24);
        6'h22: code = CODE_W'(19);
        6'h23: code = CODE_W'(25);
        6'h24: code = CODE_W'(26);
        6'h25: code = CODE_W'(11);
        6'h26: code = CODE_W'(12);
        6'h27: code = CODE_W'(13);
        default: legal = 1'b0;
      endcase
    end
  end

  // Operation classes used by sequencing and architectural-state updates
  always_comb begin
    is_shift = 1'b0;
    is_div   = 1'b0;
    is_tv    = 1'b0;
    cc_op    = 1'b0;
    y_op     = 1'b0;
    case (code)
      CODE_W'(11), CODE_W'(12), CODE_W'(13): is_shift = 1'b1;
      default: ;
    endcase
    case (code)
      CODE_W'(29), CODE_W'(30), CODE_W'(33), CODE_W'(34): is_div = 1'b1;
      default: ;
    endcase
    case (code)
      CODE_W'(19), CODE_W'(25): is_tv = 1'b1;
      default: ;
    endcase
    case (code)
      CODE_W'(2),  CODE_W'(4),  CODE_W'(6),  CODE_W'(8),  CODE_W'(10),
      CODE_W'(15), CODE_W'(17), CODE_W'(18), CODE_W'(19), CODE_W'(21),
      CODE_W'(23), CODE_W'(24), CODE_W'(25), CODE_W'(26), CODE_W'(28),
      CODE_W'(30), CODE_W'(32), CODE_W'(34): cc_op = 1'b1;
      default: ;
    endcase
    case (code)
      CODE_W'(26), CODE_W'(27), CODE_W'(28), CODE_W'(31), CODE_W'(32): y_op = 1'b1;
      default: ;
    endcase
  end

  assign op2_sel = inst_q[13] ? {{19{inst_q[12]}}, inst_q[12:0]} : rs2_data;
  assign alu_r1  = rs1_data;
  assign alu_r2  = is_shift ? {27'd0, op2_sel[4:0]} : op2_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next state and per-state strobes
  always_comb begin
    state_d         = state_q;
    inst_ready      = 1'b0;
    alu_operate     = 1'b0;
    alu_instruction = '0;
    done            = 1'b0;
    wb_data         = '0;
    trap_valid      = 1'b0;
    trap_type       = 2'd0;
    icc_ld          = 1'b0;
    y_ld            = 1'b0;
    case (state_q)
      S_IDLE: begin
        inst_ready = 1'b1;
        if (inst_valid) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        alu_instruction = code;
        state_d         = S_IDLE;
        if (is_sethi) begin
          wb_data = {inst_q[21:0], 10'd0};
          done    = 1'b1;
        end else if (!legal) begin
          trap_valid = 1'b1;
          trap_type  = 2'd1;
        end else if (is_div && (alu_r2 == 32'd0)) begin
          trap_valid = 1'b1;
          trap_type  = 2'd2;
        end else begin
          alu_operate = 1'b1;
          state_d     = S_RESULT;
        end
      end
      S_RESULT: begin
        alu_instruction = code;
        if (is_tv && alu_tof) begin
          trap_valid = 1'b1;
          trap_type  = 2'd3;
          state_d    = S_CLEAR;
        end else begin
          wb_data = alu_rd;
          done    = 1'b1;
          icc_ld  = cc_op;
          y_ld    = y_op;
          state_d = S_IDLE;
        end
      end
      default: begin
        alu_operate     = 1'b1;
        alu_instruction = CODE_CLEAR;
        state_d         = S_IDLE;
      end
    endcase
  end

  // %g0 is hard-wired zero, so its writes are dropped while still retiring
  assign wb_en = done && (wb_addr != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_q <= '0;
      icc    <= '0;
      y      <= '0;
    end else begin
      if (inst_ready && inst_valid) inst_q <= inst;
      if (icc_ld) icc <= alu_icc;
      if (y_ld)   y   <= alu_y;
    end
  end

endmodule
